// File: rtl/pool_gb_rsp_pkg.sv
// Shared definitions for the pool-side GB read responder.
// Holds the default datapath geometry and the responder FSM state type.
package pool_gb_rsp_pkg;

    localparam int unsigned PSUM_WIDTH_DEF = 23;
    localparam int unsigned NUM_LANE_DEF   = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } gb_state_e;

endpackage

// File: rtl/pool_gb_fifo2.sv
// Two-entry FIFO holding SRAM read words on their way to POOL.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, push_data - write a word (dropped if full and not popping)
//   pop, pop_data   - remove the head word; pop_data is the current head
//   full, empty     - occupancy flags
//   count           - occupancy 0..2
module pool_gb_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop;
    logic             do_push;

    // Head always sits in head_q so the output is a plain register.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        case (count_q)
            2'd0: begin
                if (do_push) begin
                    head_d  = push_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (do_push && do_pop) begin
                    head_d = push_data;
                end else if (do_push) begin
                    tail_d  = push_data;
                    count_d = 2'd2;
                end else if (do_pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (do_pop) begin
                    head_d = tail_q;
                    if (do_push) begin
                        tail_d = push_data;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign pop_data = head_q;
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;

endmodule

// File: rtl/pool_gb_rsp.sv
// GB read responder for the pooling unit. Serves CFGGB_num_rd word reads
// per feature group: POOL presents addresses, each accepted address is
// passed straight to the external GB SRAM, and the returned word is queued
// in a 2-entry FIFO toward POOL. Data returns in address-accept order.
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   CFGGB_start, CFGGB_num_rd         - start pulse and word count
//   POOLGB_addr/_addr_val, GBPOOL_addr_rdy - address channel
//   GBPOOL_data/_val, POOLGB_rdy      - data channel
//   sram_ren, sram_addr, sram_rdata   - SRAM read port (1-cycle latency)
//   GBPOOL_done, GBPOOL_busy          - completion pulse, activity flag
module pool_gb_rsp
    import pool_gb_rsp_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int unsigned NUM_LANE   = NUM_LANE_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           CFGGB_start,
    input  logic [15:0]                    CFGGB_num_rd,
    input  logic [ADDR_WIDTH-1:0]          POOLGB_addr,
    input  logic                           POOLGB_addr_val,
    output logic                           GBPOOL_addr_rdy,
    output logic [NUM_LANE*PSUM_WIDTH-1:0] GBPOOL_data,
    output logic                           GBPOOL_val,
    input  logic                           POOLGB_rdy,
    output logic                           sram_ren,
    output logic [ADDR_WIDTH-1:0]          sram_addr,
    input  logic [NUM_LANE*PSUM_WIDTH-1:0] sram_rdata,
    output logic                           GBPOOL_done,
    output logic                           GBPOOL_busy
);

    gb_state_e   state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic        inflight_q, inflight_d;
    logic        done_q, done_d;

    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  fifo_count;
    logic        fifo_push;
    logic        pop;
    logic        hs;
    logic [2:0]  used;

    assign pop = GBPOOL_val && POOLGB_rdy;

    // A word popped this cycle frees its slot for the read issued now,
    // which is what lets back-to-back reads sustain one word per cycle.
    assign used = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

    assign GBPOOL_addr_rdy = (state_q == ST_BUSY) && (remaining_q != 16'd0)
                             && (used < 3'd2);
    assign hs        = POOLGB_addr_val && GBPOOL_addr_rdy;
    assign sram_ren  = hs;
    assign sram_addr = hs ? POOLGB_addr : '0;
    assign fifo_push = inflight_q && (!fifo_full || pop);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        inflight_d  = hs;
        case (state_q)
            ST_IDLE: begin
                if (CFGGB_start) begin
                    remaining_d = CFGGB_num_rd;
                    state_d     = (CFGGB_num_rd == 16'd0) ? ST_DRAIN : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (hs) begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
        end
    end

    pool_gb_fifo2 #(
        .WIDTH (NUM_LANE*PSUM_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (sram_rdata),
        .pop       (pop),
        .pop_data  (GBPOOL_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign GBPOOL_val  = !fifo_empty;
    assign GBPOOL_done = done_q;
    assign GBPOOL_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pool_gb_rsp.sv
// Directed bench for pool_gb_rsp with a 1-cycle-latency SRAM model whose
// word is the read address replicated into every lane.
module tb_pool_gb_rsp;

    localparam int PW = 23;
    localparam int NL = 16;
    localparam int AW = 10;
    localparam int DW = NL*PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          CFGGB_start;
    logic [15:0]   CFGGB_num_rd;
    logic [AW-1:0] POOLGB_addr;
    logic          POOLGB_addr_val;
    logic          GBPOOL_addr_rdy;
    logic [DW-1:0] GBPOOL_data;
    logic          GBPOOL_val;
    logic          POOLGB_rdy;
    logic          sram_ren;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_rdata = '0;
    logic          GBPOOL_done;
    logic          GBPOOL_busy;

    pool_gb_rsp #(
        .PSUM_WIDTH (PW),
        .NUM_LANE   (NL),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .CFGGB_start     (CFGGB_start),
        .CFGGB_num_rd    (CFGGB_num_rd),
        .POOLGB_addr     (POOLGB_addr),
        .POOLGB_addr_val (POOLGB_addr_val),
        .GBPOOL_addr_rdy (GBPOOL_addr_rdy),
        .GBPOOL_data     (GBPOOL_data),
        .GBPOOL_val      (GBPOOL_val),
        .POOLGB_rdy      (POOLGB_rdy),
        .sram_ren        (sram_ren),
        .sram_addr       (sram_addr),
        .sram_rdata      (sram_rdata),
        .GBPOOL_done     (GBPOOL_done),
        .GBPOOL_busy     (GBPOOL_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rep(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = '0;
        for (int j = 0; j < NL; j++) r[j*PW +: PW] = PW'(a);
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_ren) sram_rdata <= rep(sram_addr);
    end

    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            s        = 0;
    int            n_acc, n_pop, n_ren, n_done;
    int            done_cyc, first_pop_cyc, last_pop_cyc;
    logic [AW-1:0] exp_q[$];
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data;
    logic          toggle_rdy = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_acc = 0; n_pop = 0; n_ren = 0; n_done = 0;
        done_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    endtask

    // One clock: observe at the falling edge, update inputs 1 after the rising edge.
    task automatic tick();
        logic          hs;
        logic          pp;
        logic [AW-1:0] e;
        @(negedge clk);
        hs = POOLGB_addr_val && GBPOOL_addr_rdy;
        pp = GBPOOL_val && POOLGB_rdy;
        chk("outstanding_le2", DW'((n_acc - n_pop) <= 2), DW'(1'b1));
        chk("ren_eq_handshake", DW'(sram_ren), DW'(hs));
        if (sram_ren) n_ren++;
        if (hs) begin
            chk("sram_addr_passthru", DW'(sram_addr), DW'(POOLGB_addr));
            exp_q.push_back(POOLGB_addr);
            n_acc++;
        end
        if (hold_prev) chk("head_stable", GBPOOL_data, hold_data);
        hold_prev = GBPOOL_val && !POOLGB_rdy;
        hold_data = GBPOOL_data;
        if (pp) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            chk("pop_data_order", GBPOOL_data, rep(e));
            n_pop++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (GBPOOL_done) begin
            n_done++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs) POOLGB_addr = POOLGB_addr + 1'b1;
        if (toggle_rdy) POOLGB_rdy = ~POOLGB_rdy;
    endtask

    task automatic start(input logic [15:0] n);
        CFGGB_num_rd = n;
        CFGGB_start  = 1'b1;
        s = cyc;
        tick();
        CFGGB_start  = 1'b0;
    endtask

    task automatic run_until_done(input int max);
        int k;
        k = 0;
        while (n_done == 0 && k < max) begin
            tick();
            k++;
        end
        tick();
        tick();
        chk("done_single_pulse", DW'(n_done), DW'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_val"},     DW'(GBPOOL_val), '0);
        chk({tag, "_data"},    GBPOOL_data, '0);
        chk({tag, "_addr_rdy"}, DW'(GBPOOL_addr_rdy), '0);
        chk({tag, "_ren"},     DW'(sram_ren), '0);
        chk({tag, "_sram_addr"}, DW'(sram_addr), '0);
        chk({tag, "_done"},    DW'(GBPOOL_done), '0);
        chk({tag, "_busy"},    DW'(GBPOOL_busy), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b0;
        CFGGB_start = 1'b0;
        CFGGB_num_rd = '0;
        POOLGB_addr = 10'd0;
        POOLGB_addr_val = 1'b1;
        POOLGB_rdy = 1'b0;
        clear_stats();
        #1 rst = 1'b1;
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic 4-word run, one word per cycle.
        clear_stats();
        POOLGB_addr = 10'd5;
        POOLGB_rdy = 1'b1;
        start(16'd4);
        chk("busy_after_start", DW'(GBPOOL_busy), DW'(1'b1));
        run_until_done(40);
        chk("t1_pops", DW'(n_pop), DW'(4));
        chk("t1_reads", DW'(n_ren), DW'(4));
        chk("t1_first_pop", DW'(first_pop_cyc), DW'(s + 3));
        chk("t1_last_pop", DW'(last_pop_cyc), DW'(s + 6));
        chk("t1_done_cyc", DW'(done_cyc), DW'(s + 8));
        chk("t1_idle_busy", DW'(GBPOOL_busy), DW'(1'b0));

        // Zero-length group.
        clear_stats();
        start(16'd0);
        run_until_done(10);
        chk("t2_done_cyc", DW'(done_cyc), DW'(s + 2));
        chk("t2_no_reads", DW'(n_ren), DW'(0));

        // Consumer stalled for 10 cycles.
        clear_stats();
        POOLGB_addr = 10'd100;
        POOLGB_rdy = 1'b0;
        start(16'd6);
        repeat (10) tick();
        chk("t3_reads_stalled", DW'(n_ren), DW'(2));
        chk("t3_addr_rdy_low", DW'(GBPOOL_addr_rdy), DW'(1'b0));
        chk("t3_val_high", DW'(GBPOOL_val), DW'(1'b1));
        chk("t3_head", GBPOOL_data, rep(10'd100));
        POOLGB_rdy = 1'b1;
        run_until_done(60);
        chk("t3_pops", DW'(n_pop), DW'(6));
        chk("t3_accepts", DW'(n_acc), DW'(6));

        // Consumer ready toggling every cycle.
        clear_stats();
        POOLGB_addr = 10'd200;
        POOLGB_rdy = 1'b1;
        toggle_rdy = 1'b1;
        start(16'd8);
        run_until_done(100);
        toggle_rdy = 1'b0;
        POOLGB_rdy = 1'b1;
        chk("t4_pops", DW'(n_pop), DW'(8));
        chk("t4_accepts", DW'(n_acc), DW'(8));

        // Start while busy is ignored.
        clear_stats();
        POOLGB_addr = 10'd300;
        start(16'd3);
        CFGGB_num_rd = 16'd7;
        CFGGB_start = 1'b1;
        tick();
        CFGGB_start = 1'b0;
        run_until_done(40);
        repeat (3) tick();
        chk("t5_accepts", DW'(n_acc), DW'(3));
        chk("t5_pops", DW'(n_pop), DW'(3));
        chk("t5_reads", DW'(n_ren), DW'(3));

        // Reset with a read in flight.
        clear_stats();
        POOLGB_addr = 10'd400;
        start(16'd8);
        k = 0;
        while (n_acc < 3 && k < 20) begin
            tick();
            k++;
        end
        chk("t6_three_accepted", DW'(n_acc), DW'(3));
        rst = 1'b1;
        #1;
        chk_all_zero("t6_in_reset");
        exp_q.delete();
        hold_prev = 1'b0;
        clear_stats();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("t6_no_stale_pop", DW'(n_pop), DW'(0));
        chk("t6_no_reads", DW'(n_ren), DW'(0));
        chk("t6_idle", DW'(GBPOOL_busy), DW'(1'b0));

        // Recovery after reset.
        clear_stats();
        POOLGB_addr = 10'd500;
        start(16'd1);
        run_until_done(20);
        chk("t7_pops", DW'(n_pop), DW'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
